// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit with an elastic valid/ready register chain.
// Define LOGIC_UNIT_PIPE_PARITY_EN to add the registered y_parity output.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  ,
  output logic             y_parity
`endif
);

  if (STAGES < 1) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] res;

  always_comb begin
    res = '0;
    unique case (op_e'(op))
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_PASS: res = a;
      default: res = '0;
    endcase
  end

  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0][WIDTH-1:0] y_q;
  logic [STAGES-1:0]            z_q;
  logic [STAGES-1:0]            adv;
  logic                         full;

  // Index k of src_* is what stage k loads: element 0 is the fresh result.
  logic [STAGES:0]              src_v;
  logic [STAGES:0][WIDTH-1:0]   src_y;
  logic [STAGES:0]              src_z;

  assign src_v = {vld_q, in_valid};
  assign src_y = {y_q, res};
  assign src_z = {z_q, ~|res};

  // A stage stalls only if it and every stage after it hold data
  // and the sink is not taking the last one.
  always_comb begin
    adv  = '0;
    full = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full = full & vld_q[j];
      end
      adv[k] = out_ready | ~full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_q[k] <= src_v[k];
          if (src_v[k]) begin
            y_q[k] <= src_y[k];
            z_q[k] <= src_z[k];
          end
        end
      end
    end
  end

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  logic [STAGES-1:0] p_q;
  logic [STAGES:0]   src_p;

  assign src_p = {p_q, ^res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k] && src_v[k]) begin
          p_q[k] <= src_p[k];
        end
      end
    end
  end

  assign y_parity = p_q[STAGES-1];
`endif

  assign in_ready  = adv[0];
  assign out_valid = vld_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign y_zero    = z_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (8-bit/2-stage and 1-bit/1-stage).
// Define LOGIC_UNIT_PIPE_PARITY_EN to also check y_parity.
module tb_logic_unit_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         y_zero;

  logic         v1, r1, ov1, or1, y1, z1;
  logic [2:0]   op1;
  logic         a1, b1;

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  logic         y_parity;
  logic         p1;
`endif

  logic_unit_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_zero(y_zero)
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    , .y_parity(y_parity)
`endif
  );

  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1),
    .op(op1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1),
    .y(y1), .y_zero(z1)
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    , .y_parity(p1)
`endif
  );

  typedef struct {
    logic [W-1:0] y;
    logic         z;
    logic         p;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   lat_chk = 0;
  bit   rnd_or  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [W-1:0] v);
    exp_t e;
    e.y = v;
    e.z = (v == '0);
    e.p = ^v;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] model(input logic [2:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] z);
    case (o)
      3'd0: return ~x;
      3'd1: return x & z;
      3'd2: return x | z;
      3'd3: return x ^ z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious: y=%0h with no beat pending", y);
        end else begin
          e = sb[0];
          if (y !== e.y || y_zero !== e.z) begin
            errors++;
            $display("FAIL result: y=%0h z=%0b expected y=%0h z=%0b",
                     y, y_zero, e.y, e.z);
          end
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
          vectors++;
          if (y_parity !== e.p) begin
            errors++;
            $display("FAIL parity: got %0b expected %0b", y_parity, e.p);
          end
`endif
          if (out_ready) begin
            if (lat_chk) begin
              vectors++;
              if (cyc - e.acc != S) begin
                errors++;
                $display("FAIL latency: got %0d expected %0d",
                         cyc - e.acc, S);
              end
            end
            void'(sb.pop_front());
          end
        end
      end
    end
  endtask

  task automatic rnd_ready();
    forever begin
      @(posedge clk);
      #1;
      if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] xa,
                      input logic [W-1:0] xb, input exp_t e,
                      output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    in_valid = 1'b1;
    op = o;
    a = xa;
    b = xb;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        sb.push_back(e);
        ok = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", sb.size(), 0);
  endtask

  logic [2:0]   cop [4];
  logic [W-1:0] ca  [4];
  logic [W-1:0] cb  [4];
  logic [W-1:0] cy  [4];
  logic [W-1:0] vexp [8];
  int           wt;
  int           idx;

  initial begin
    fork
      monitor();
      rnd_ready();
    join_none

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    v1 = 1'b0; or1 = 1'b1; op1 = 3'b000; a1 = 1'b0; b1 = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_y_zero", y_zero, 0);
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    chk("rst_parity", y_parity, 0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // 1-bit inverter: NOT 0 -> 1, NOT 1 -> 0, one cycle after accept
    @(posedge clk); #1;
    v1 = 1'b1; a1 = 1'b0;
    @(negedge clk);
    chk("inv_ready", r1, 1);
    @(posedge clk); #1;
    a1 = 1'b1;
    @(negedge clk);
    chk("inv0_valid", ov1, 1);
    chk("inv0_y", y1, 1);
    chk("inv0_zero", z1, 0);
    @(posedge clk); #1;
    v1 = 1'b0;
    @(negedge clk);
    chk("inv1_valid", ov1, 1);
    chk("inv1_y", y1, 0);
    chk("inv1_zero", z1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("inv_idle", ov1, 0);
    @(posedge clk); #1;

    // all eight ops back to back on F0/3C
    vexp[0] = 8'h0F; vexp[1] = 8'h30; vexp[2] = 8'hFC; vexp[3] = 8'hCC;
    vexp[4] = 8'hCF; vexp[5] = 8'h03; vexp[6] = 8'h33; vexp[7] = 8'hF0;
    out_ready = 1'b1;
    lat_chk = 1;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 8'hF0, 8'h3C, mk(vexp[i]), wt);
      chk("b2b_in_ready", wt, 0);
    end
    drain();
    lat_chk = 0;

    // capacity under backpressure then release
    cop[0] = 3'b001; ca[0] = 8'hAA; cb[0] = 8'h0F; cy[0] = 8'h0A;
    cop[1] = 3'b010; ca[1] = 8'h11; cb[1] = 8'h22; cy[1] = 8'h33;
    cop[2] = 3'b011; ca[2] = 8'hFF; cb[2] = 8'hFF; cy[2] = 8'h00;
    cop[3] = 3'b101; ca[3] = 8'h00; cb[3] = 8'h00; cy[3] = 8'hFF;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      op = cop[idx]; a = ca[idx]; b = cb[idx];
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(mk(cy[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("cap_accepted", idx, S);
    chk("cap_in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = idx; i < 4; i++) send(cop[i], ca[i], cb[i], mk(cy[i]), wt);
    drain();

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    send(3'b011, 8'h07, 8'h00, mk(8'h07), wt);
    drain();
`endif

    // random handshakes against the model
    rnd_or = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
      send(ro, ra, rb, mk(model(ro, ra, rb)), wt);
    end
    rnd_or = 0;
    out_ready = 1'b1;
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(3'b001, 8'h55, 8'hFF, mk(8'h55), wt);
    send(3'b111, 8'hC3, 8'h00, mk(8'hC3), wt);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_stale", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
